npu_inst_fetch: RTL and testbench

Instruction prefetch stage sitting between the SDRAM read wrapper and the `cpu` instruction port inside `design_top`. It issues sequential 32-bit word reads starting at a programmable PC, keeps up to `DEPTH` words in flight or buffered, and presents them in order to the CPU with a valid/ready handshake. A redirect from the CPU flushes buffered words and discards in-flight responses belonging to the old stream. Fetching is gated by an enable bit driven from the host PIO register.

---
 rtl/npu_inst_fetch_if.sv | 24 ++
 rtl/npu_inst_fetch.sv | 95 +++++++++
 tb/tb_npu_inst_fetch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/npu_inst_fetch_if.sv
// npu_inst_fetch_if: CPU instruction port, SDRAM read port and control bits for the fetch stage
interface npu_inst_fetch_if #(parameter int ADDR_W = 32);
  logic              enable;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic [31:0]       rd_resp_data;
  logic              busy;
  modport master (
    input  enable, redirect_valid, redirect_addr, inst_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
    output inst_valid, inst_data, inst_pc, rd_req_valid, rd_addr, busy
  );
  modport slave (
    output enable, redirect_valid, redirect_addr, inst_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
    input  inst_valid, inst_data, inst_pc, rd_req_valid, rd_addr, busy
  );
endinterface

// File: rtl/npu_inst_fetch.sv
// npu_inst_fetch: sequential instruction prefetch queue with redirect flush and stale-response discard
module npu_inst_fetch #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  npu_inst_fetch_if.master      bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     q_cnt_q, q_cnt_d, inflight_q, inflight_d, stale_q, stale_d;
  logic [CW:0]       total_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, exp_pc_q, exp_pc_d, rpc;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       inst_data_q, inst_data_d;
  logic              inst_valid_q, inst_valid_d, rd_req_valid_q, rd_req_valid_d, busy_q, busy_d;
  logic              redir, acc, pop, drop, push, bypass;
  logic [31:0]       mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  always_comb begin
    redir          = bus.redirect_valid;
    rpc            = bus.redirect_addr & ~ADDR_W'(3);
    acc            = rd_req_valid_q && bus.rd_req_ready;
    pop            = inst_valid_q && bus.inst_ready && !redir;
    drop           = bus.rd_resp_valid && (redir || stale_q != '0);
    push           = bus.rd_resp_valid && !drop;
    // on redirect every outstanding read, including one accepted this cycle, belongs to the old stream
    stale_d        = redir ? stale_q + inflight_q + CW'(acc) - CW'(bus.rd_resp_valid) : stale_q - CW'(drop);
    inflight_d     = redir ? '0 : inflight_q + CW'(acc) - CW'(push);
    q_cnt_d        = redir ? '0 : q_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d       = wr_ptr_q + PW'(push);
    rd_ptr_d       = redir ? wr_ptr_q : rd_ptr_q + PW'(pop);
    fetch_pc_d     = redir ? rpc : fetch_pc_q + (acc ? ADDR_W'(4) : '0);
    exp_pc_d       = redir ? rpc : exp_pc_q + (push ? ADDR_W'(4) : '0);
    state_d        = (state_q == IDLE) ? (bus.enable ? RUN : IDLE) :
                     bus.enable ? RUN :
                     (state_q == RUN || (inflight_d | stale_d) != '0) ? DRAIN : IDLE;
    total_d        = {1'b0, q_cnt_d} + {1'b0, inflight_d} + {1'b0, stale_d};
    rd_req_valid_d = (state_d == RUN) && (total_d < (CW+1)'(DEPTH));
    busy_d         = (state_d != IDLE) || (inflight_d | stale_d) != '0;
    inst_valid_d   = q_cnt_d != '0;
    // a word pushed into an empty (or emptying) queue becomes the head without waiting for its write
    bypass         = push && (q_cnt_q == CW'(pop));
    inst_data_d    = !inst_valid_d ? inst_data_q : bypass ? bus.rd_resp_data : mem_data[rd_ptr_d];
    inst_pc_d      = !inst_valid_d ? inst_pc_q : bypass ? exp_pc_q : mem_pc[rd_ptr_d];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      q_cnt_q        <= '0;
      inflight_q     <= '0;
      stale_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fetch_pc_q     <= RESET_PC;
      exp_pc_q       <= RESET_PC;
      inst_valid_q   <= 1'b0;
      inst_data_q    <= '0;
      inst_pc_q      <= '0;
      rd_req_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_cnt_q        <= q_cnt_d;
      inflight_q     <= inflight_d;
      stale_q        <= stale_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fetch_pc_q     <= fetch_pc_d;
      exp_pc_q       <= exp_pc_d;
      inst_valid_q   <= inst_valid_d;
      inst_data_q    <= inst_data_d;
      inst_pc_q      <= inst_pc_d;
      rd_req_valid_q <= rd_req_valid_d;
      busy_q         <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= bus.rd_resp_data;
      mem_pc[wr_ptr_q]   <= exp_pc_q;
    end
  end
  assign bus.inst_valid   = inst_valid_q;
  assign bus.inst_data    = inst_data_q;
  assign bus.inst_pc      = inst_pc_q;
  assign bus.rd_req_valid = rd_req_valid_q;
  assign bus.rd_addr      = fetch_pc_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_npu_inst_fetch.sv
// tb_npu_inst_fetch: randomized and directed checks of the fetch stage against a queue-based reference model
module tb_npu_inst_fetch;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  npu_inst_fetch_if #(.ADDR_W(32)) bus ();
  npu_inst_fetch #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {logic [31:0] addr; logic [31:0] data; bit st; int due;} ent_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} word_t;
  ent_t        m_out[$];
  word_t       m_q[$];
  int          m_state;
  logic [31:0] m_fpc;
  bit          m_rv, m_busy, armed;
  int          cyc, last_due, total, bad;
  bit          k_en;
  int          k_rdy, k_req, k_lat_lo, k_lat_hi;
  logic [31:0] acc_log[$], del_log[$];
  int          first_valid_cyc, last_resp_cyc;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  function automatic logic [31:0] dl(input int i);
    return (i < del_log.size()) ? del_log[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] al(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
  endfunction
  task automatic step(input bit redir, input logic [31:0] raddr, input bit rst);
    bit rdy, rreq, resp, acc;
    int lat, d;
    ent_t e;
    @(negedge clk);
    cyc++;
    if (armed) begin
      chk("inst_valid", bus.inst_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("inst_pc", bus.inst_pc, m_q[0].pc);
        chk("inst_data", bus.inst_data, m_q[0].data);
      end
      chk("rd_req_valid", bus.rd_req_valid, m_rv);
      if (m_rv) chk("rd_addr", bus.rd_addr, m_fpc);
      chk("busy", bus.busy, m_busy);
    end
    if (bus.inst_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    rdy  = ($urandom % 100) < k_rdy;
    rreq = ($urandom % 100) < k_req;
    resp = !rst && m_out.size() != 0 && m_out[0].due <= cyc;
    lat  = $urandom_range(k_lat_hi, k_lat_lo);
    rst_n              = !rst;
    bus.enable         = k_en;
    bus.redirect_valid = redir;
    bus.redirect_addr  = raddr;
    bus.inst_ready     = rdy;
    bus.rd_req_ready   = rreq;
    bus.rd_resp_valid  = resp;
    bus.rd_resp_data   = resp ? m_out[0].data : $urandom;
    if (resp) last_resp_cyc = cyc;
    if (!rst && bus.inst_valid === 1'b1 && rdy && !redir) del_log.push_back(bus.inst_pc);
    if (!rst && bus.rd_req_valid === 1'b1 && rreq) acc_log.push_back(bus.rd_addr);
    if (rst) begin
      m_out.delete();
      m_q.delete();
      m_state  = 0;
      m_fpc    = 32'h0;
      m_rv     = 1'b0;
      m_busy   = 1'b0;
      last_due = 0;
      armed    = 1'b1;
    end else begin
      acc = m_rv && rreq;
      if (m_q.size() != 0 && rdy && !redir) void'(m_q.pop_front());
      if (resp) begin
        e = m_out.pop_front();
        if (!e.st && !redir) m_q.push_back('{e.addr, e.data});
      end
      if (acc) begin
        d = (last_due + 1 > cyc + lat) ? last_due + 1 : cyc + lat;
        last_due = d;
        m_out.push_back('{m_fpc, $urandom, redir, d});
        m_fpc += 32'd4;
      end
      if (redir) begin
        m_q.delete();
        foreach (m_out[i]) m_out[i].st = 1'b1;
        m_fpc = raddr & ~32'd3;
      end
      if (m_state == 0) m_state = k_en ? 1 : 0;
      else if (k_en) m_state = 1;
      else if (m_state == 1) m_state = 2;
      else m_state = (m_out.size() == 0) ? 0 : 2;
      m_rv   = (m_state == 1) && (m_q.size() + m_out.size() < DEPTH);
      m_busy = (m_state != 0) || (m_out.size() != 0);
    end
  endtask
  task automatic do_reset();
    k_en = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    acc_log.delete();
    del_log.delete();
    first_valid_cyc = -1;
  endtask
  task automatic run_until_del(input int n, input int budget);
    int i;
    for (i = 0; i < budget && del_log.size() < n; i++) step(1'b0, 32'h0, 1'b0);
    if (del_log.size() < n) chk("deliver_timeout", del_log.size(), n);
  endtask
  task automatic run_until_acc(input int n, input int budget);
    int i;
    for (i = 0; i < budget && acc_log.size() < n; i++) step(1'b0, 32'h0, 1'b0);
    if (acc_log.size() < n) chk("accept_timeout", acc_log.size(), n);
  endtask
  initial begin
    int en_cyc, n0, i, zero_cyc;
    bit hit;
    logic [31:0] ra;
    total = 0; bad = 0; cyc = 0; armed = 1'b0; first_valid_cyc = -1; last_resp_cyc = 0;
    k_en = 1'b0; k_rdy = 100; k_req = 100; k_lat_lo = 3; k_lat_hi = 3;
    bus.enable = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.inst_ready = 1'b0;
    bus.rd_req_ready = 1'b0; bus.rd_resp_valid = 1'b0; bus.rd_resp_data = '0;
    do_reset();
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst_data", bus.inst_data, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_rd_req_valid", bus.rd_req_valid, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_busy", bus.busy, 0);
    k_en = 1'b1;
    en_cyc = cyc + 1;
    run_until_del(4, 40);
    chk("a_req0", al(0), 32'h0);
    chk("a_req1", al(1), 32'h4);
    chk("a_req2", al(2), 32'h8);
    chk("a_req3", al(3), 32'hC);
    chk("a_pc0", dl(0), 32'h0);
    chk("a_pc3", dl(3), 32'hC);
    chk("a_first_valid", first_valid_cyc - en_cyc, 5);
    do_reset();
    k_lat_lo = 1; k_lat_hi = 1; k_en = 1'b1;
    for (i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    n0 = del_log.size();
    for (i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0);
    chk("throughput", del_log.size() - n0, 20);
    do_reset();
    k_rdy = 0; k_lat_lo = 2; k_lat_hi = 2; k_en = 1'b1;
    for (i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0);
    chk("b_accepts", acc_log.size(), 4);
    chk("b_req_stall", bus.rd_req_valid, 0);
    k_rdy = 100;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("b_resume", bus.rd_req_valid, 1);
    do_reset();
    k_lat_lo = 8; k_lat_hi = 8; k_en = 1'b1;
    run_until_acc(3, 20);
    k_req = 0;
    step(1'b1, 32'h103, 1'b0);
    k_req = 100;
    del_log.delete();
    run_until_del(2, 60);
    chk("c_pc0", dl(0), 32'h100);
    chk("c_pc1", dl(1), 32'h104);
    do_reset();
    k_lat_lo = 2; k_lat_hi = 2; k_en = 1'b1;
    hit = 1'b0;
    for (i = 0; i < 30 && !hit; i++) begin
      if (m_rv && m_out.size() != 0 && m_out[0].due <= cyc + 1) hit = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    chk("d_coincide", hit, 1);
    step(1'b1, 32'h200, 1'b0);
    del_log.delete();
    run_until_del(2, 60);
    chk("d_pc0", dl(0), 32'h200);
    chk("d_pc1", dl(1), 32'h204);
    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    del_log.delete();
    run_until_del(3, 60);
    chk("e_pc0", dl(0), 32'hFFFF_FFF8);
    chk("e_pc1", dl(1), 32'hFFFF_FFFC);
    chk("e_pc2", dl(2), 32'h0);
    do_reset();
    k_lat_lo = 6; k_lat_hi = 6; k_en = 1'b1;
    run_until_acc(2, 20);
    k_req = 0; k_en = 1'b0;
    zero_cyc = -1;
    for (i = 0; i < 40 && zero_cyc < 0; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (bus.busy === 1'b0) zero_cyc = cyc;
    end
    chk("f_delivered", del_log.size(), 2);
    chk("f_busy_fall", zero_cyc - last_resp_cyc, 1);
    k_req = 100;
    do_reset();
    for (i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        k_rdy = $urandom_range(100, 20);
        k_req = $urandom_range(100, 20);
        k_lat_lo = $urandom_range(3, 1);
        k_lat_hi = k_lat_lo + $urandom_range(4, 0);
      end
      if ($urandom % 100 < 4) k_en = !k_en;
      if ($urandom % 1000 < 3) step(1'b0, 32'h0, 1'b1);
      else if ($urandom % 100 < 4) begin
        ra = ($urandom % 2) ? $urandom : (32'hFFFF_FFF0 | ($urandom % 16));
        step(1'b1, ra, 1'b0);
      end else step(1'b0, 32'h0, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
